axil_cfg_sequencer: RTL and testbench
=====================================

Name: axil_cfg_sequencer

Overview:
- Synthesisable AXI4-Lite master that replays a programmed command list into the block-design register space (measurer, averager, ...), replacing scripted host writes and polls.
- Commands: register writes, delays, and read-polls on status bits.
- Parametrised in address/data width and command depth.
- Sits beside the PS AXI master on the same AXI interconnect. Used for autonomous bring-up and re-arming after each averaging run.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (32 or 64)
DEPTH, 32, command slots; power of 2
POLL_GAP, 16, idle cycles between successive poll reads
POLL_MAX, 1024, poll read limit (only with timeout feature)

Ports:
ap_clk  in  1  clock; all logic on rising edge
ap_rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begin execution at slot 0
busy  out  1  sequence running
done  out  1  sticky; END reached or last slot executed
error  out  1  sticky; AXI SLVERR/DECERR or poll timeout
err_idx  out  log2(DEPTH)  slot index of the failing command
last_rdata  out  DATA_W  data from the most recent read
cmd_we  in  1  command table write strobe
cmd_waddr  in  log2(DEPTH)  command slot
cmd_wdata  in  2+ADDR_W+DATA_W  {op[1:0], addr, data}; op 0=WRITE, 1=POLL, 2=WAIT, 3=END
m_axil_aw*/w*/b*/ar*/r*  -  std  AXI4-Lite master: awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready

Behaviour:
- Interface: one clock `ap_clk`; reset `ap_rst` is synchronous and active-high.
- Reset values:
  - All valid/ready outputs = 0; busy/done/error = 0; err_idx = 0; last_rdata = 0.
  - pc = 0; state IDLE.
  - Command table contents are NOT cleared.
  - Reset mid-transaction drops valids on the next edge; no completion is awaited.
- Command table: single-port RAM, 1-cycle read latency.
  - cmd_we is ignored while busy=1.
- start is ignored unless in state IDLE, DONE or ERR.
  - Accepted start clears done/error, sets pc=0 and busy=1 in the next cycle.
- States:
  - IDLE → FETCH on start.
  - FETCH: 1 cycle RAM read, then decode:
    - WRITE → WR
    - POLL → RD
    - WAIT → DLY
    - END → DONE
  - WR: awvalid=wvalid=1 together; wstrb all ones. Each valid drops independently on its own handshake. When both have completed → BR.
  - BR: bready=1.
    - On bvalid with bresp != 0 → ERR.
    - Otherwise advance.
  - RD: arvalid=1 until arready → RR.
  - RR: rready=1. On rvalid: last_rdata <= rdata.
    - rresp != 0 → ERR.
    - (rdata & data) == data → advance.
    - Otherwise → GAP.
  - GAP: count POLL_GAP cycles → RD.
  - DLY: count `data` cycles (data=0 → 1 cycle) → advance.
  - Advance: pc+1 → FETCH. If pc == DEPTH-1, go to DONE instead (no wrap).
  - DONE: done=1, busy=0.
  - ERR: error=1, busy=0, err_idx=pc.
- At most one AXI transaction is outstanding at any time.
- Addresses pass through unmodified; no alignment check.
- Minimum WRITE time with zero-wait slave: FETCH 1 + WR 1 + BR 1 = 3 cycles per command.

Optional Feature:
- Macro `AXIL_SEQ_POLL_TIMEOUT_EN`.
- Defined:
  - Per-POLL read counter, cleared in FETCH.
  - Reaching POLL_MAX reads without a match → ERR with err_idx = pc.
- Undefined:
  - Poll retries indefinitely.
  - POLL_MAX is unused.

Test Plan:
- Write to measurer:
  - Stimulus: load {WRITE,0x10010,13824}, {WRITE,0x10000,129}, {END}; then start.
  - Required: slave sees exactly these two writes in order, wstrb=0xF; done=1 and busy=0 within 12 cycles of start (zero-wait slave).
- Averager write sequence:
  - Stimulus: {WRITE,0x10,0}, {WRITE,0x1C,120000}, {WRITE,0x28,5}, {WRITE,0x30,1}, {WRITE,0x0,129}, {END}.
  - Required: 5 ordered writes; awvalid and wvalid skewed independently by the slave (awready delayed 3 cycles, wready 0) still produce exactly one write each.
- Poll:
  - Stimulus: {POLL,0x38,0x2}; slave returns 0x0 three times, then 0x6.
  - Required: 4 reads, spaced ≥ POLL_GAP cycles apart; last_rdata=0x6; done=1.
- Error:
  - Stimulus: slave returns bresp=2 on the 2nd write.
  - Required: error=1, err_idx=1, no further AXI activity.
  - Then start again with OK responses → error clears, done=1.
- Delay and reset:
  - Stimulus: {WAIT,-,100} between two writes.
  - Required: gap of exactly 100 cycles + overhead between the two awvalid rises.
  - Assert ap_rst during the WAIT → all outputs return to reset values next cycle.
- Timeout (macro defined):
  - Stimulus: POLL_MAX=4, slave always returns 0.
  - Required: exactly 4 reads, then error=1.

Source files
------------

// File: rtl/axil_cfg_sequencer_if.sv
// rtl/axil_cfg_sequencer_if.sv - AXI4-Lite bundle between the config sequencer and the interconnect
interface axil_cfg_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_cfg_sequencer.sv
// rtl/axil_cfg_sequencer.sv - AXI4-Lite master replaying a command list of writes, polls and waits
// Optional poll read limit enabled by defining AXIL_SEQ_POLL_TIMEOUT_EN.
module axil_cfg_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 1024
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [$clog2(DEPTH)-1:0]    err_idx,
  output logic [DATA_W-1:0]           last_rdata,
  input  logic                        cmd_we,
  input  logic [$clog2(DEPTH)-1:0]    cmd_waddr,
  input  logic [2+ADDR_W+DATA_W-1:0]  cmd_wdata,
  axil_cfg_sequencer_if.master        m_axil
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CMD_W = 2 + ADDR_W + DATA_W;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_WAIT  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR, S_BR, S_RD, S_RR, S_GAP, S_DLY, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W:0]     cnt_inc;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic [IDX_W-1:0]    err_idx_q, err_idx_d;
  logic [DATA_W-1:0]   last_rdata_q, last_rdata_d;
  logic                advance, fail;

  logic [CMD_W-1:0]    cmd_mem [DEPTH];
  logic [CMD_W-1:0]    cmd_rd_q;
  logic [1:0]          cmd_op;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_data;

  assign busy = !(state_q inside {S_IDLE, S_DONE, S_ERR});

  // Addressed by pc_d so the entry for the new pc is on cmd_rd_q in FETCH.
  always_ff @(posedge ap_clk) begin
    if (cmd_we && !busy) begin
      cmd_mem[cmd_waddr] <= cmd_wdata;
    end
    cmd_rd_q <= cmd_mem[pc_d];
  end

  assign cmd_op   = cmd_rd_q[CMD_W-1 -: 2];
  assign cmd_addr = cmd_rd_q[DATA_W +: ADDR_W];
  assign cmd_data = cmd_rd_q[DATA_W-1:0];
  assign cnt_inc  = {1'b0, cnt_q} + {{DATA_W{1'b0}}, 1'b1};

`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
  localparam int PC_W = $clog2(POLL_MAX + 1);
  logic [PC_W-1:0] poll_cnt_q, poll_cnt_d;
`else
  logic unused_poll_max;
  assign unused_poll_max = (POLL_MAX != 0);
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    err_idx_d    = err_idx_q;
    last_rdata_d = last_rdata_q;
    advance      = 1'b0;
    fail         = 1'b0;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
    poll_cnt_d   = poll_cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
        poll_cnt_d = '0;
`endif
        case (cmd_op)
          OP_WRITE: begin
            state_d   = S_WR;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end
          OP_POLL: state_d = S_RD;
          OP_WAIT: begin
            state_d = S_DLY;
            cnt_d   = '0;
          end
          default: state_d = S_DONE;
        endcase
      end
      S_WR: begin
        if (m_axil.awready) aw_pend_d = 1'b0;
        if (m_axil.wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = S_BR;
      end
      S_BR: begin
        if (m_axil.bvalid) begin
          if (m_axil.bresp != 2'b00) fail = 1'b1;
          else                       advance = 1'b1;
        end
      end
      S_RD: begin
        if (m_axil.arready) state_d = S_RR;
      end
      S_RR: begin
        if (m_axil.rvalid) begin
          last_rdata_d = m_axil.rdata;
          if (m_axil.rresp != 2'b00) begin
            fail = 1'b1;
          end else if ((m_axil.rdata & cmd_data) == cmd_data) begin
            advance = 1'b1;
          end else begin
            state_d = S_GAP;
            cnt_d   = '0;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
            poll_cnt_d = poll_cnt_q + PC_W'(1);
            if (poll_cnt_d == PC_W'(POLL_MAX)) fail = 1'b1;
`endif
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_inc[DATA_W-1:0];
        if (cnt_q == DATA_W'(POLL_GAP - 1)) state_d = S_RD;
      end
      S_DLY: begin
        // A zero count still spends one cycle here.
        cnt_d = cnt_inc[DATA_W-1:0];
        if (cnt_inc >= {1'b0, cmd_data}) advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (pc_q == IDX_W'(DEPTH - 1)) begin
        state_d = S_DONE;
      end else begin
        pc_d    = pc_q + IDX_W'(1);
        state_d = S_FETCH;
      end
    end
    if (fail) begin
      state_d   = S_ERR;
      err_idx_d = pc_q;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      cnt_q        <= '0;
      aw_pend_q    <= 1'b0;
      w_pend_q     <= 1'b0;
      err_idx_q    <= '0;
      last_rdata_q <= '0;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
      poll_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      aw_pend_q    <= aw_pend_d;
      w_pend_q     <= w_pend_d;
      err_idx_q    <= err_idx_d;
      last_rdata_q <= last_rdata_d;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
      poll_cnt_q   <= poll_cnt_d;
`endif
    end
  end

  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign err_idx    = err_idx_q;
  assign last_rdata = last_rdata_q;

  assign m_axil.awaddr  = cmd_addr;
  assign m_axil.awvalid = aw_pend_q;
  assign m_axil.wdata   = cmd_data;
  assign m_axil.wstrb   = '1;
  assign m_axil.wvalid  = w_pend_q;
  assign m_axil.bready  = (state_q == S_BR);
  assign m_axil.araddr  = cmd_addr;
  assign m_axil.arvalid = (state_q == S_RD);
  assign m_axil.rready  = (state_q == S_RR);
endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// tb/tb_axil_cfg_sequencer.sv - directed bench for axil_cfg_sequencer with a small AXI4-Lite slave
module tb_axil_cfg_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int IW = 5;
  localparam int POLL_GAP = 16;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic start = 1'b0;
  logic cmd_we = 1'b0;
  logic [IW-1:0] cmd_waddr = '0;
  logic [2+AW+DW-1:0] cmd_wdata = '0;
  logic busy, done, error;
  logic [IW-1:0] err_idx;
  logic [DW-1:0] last_rdata;

  axil_cfg_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axil_cfg_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .POLL_GAP(POLL_GAP), .POLL_MAX(4)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start),
    .busy(busy), .done(done), .error(error),
    .err_idx(err_idx), .last_rdata(last_rdata),
    .cmd_we(cmd_we), .cmd_waddr(cmd_waddr), .cmd_wdata(cmd_wdata),
    .m_axil(bus)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int aw_dly = 0, w_dly = 0, b_err_at = -1, wr_base = 0, rd_base = 0;
  logic [31:0] rd_vals [8];

  int aw_cnt = 0, w_cnt = 0;
  logic aw_got = 1'b0, w_got = 1'b0, aw_prev = 1'b0;
  logic [31:0] aw_addr_l = '0, w_data_l = '0;
  logic [3:0]  w_strb_l = '0;
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  logic [3:0]  wr_strb_q[$];
  int aw_rise_q[$], rd_cyc_q[$];
  logic bvalid_r = 1'b0, rvalid_r = 1'b0;
  logic [1:0] bresp_r = '0;
  logic [31:0] rdata_r = '0;

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
  assign bus.wready  = bus.wvalid && (w_cnt >= w_dly);
  assign bus.arready = bus.arvalid;
  assign bus.bvalid  = bvalid_r;
  assign bus.bresp   = bresp_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = 2'b00;

  always @(posedge ap_clk) begin
    logic aw_hs, w_hs, have_aw, have_w;
    logic [31:0] a, d;
    logic [3:0] s;
    int ri;
    aw_hs = bus.awvalid && bus.awready;
    w_hs  = bus.wvalid && bus.wready;
    if (ap_rst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; aw_prev <= 1'b0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0;
    end else begin
      if (bus.awvalid && !aw_prev) aw_rise_q.push_back(cyc);
      aw_prev <= bus.awvalid;
      aw_cnt <= aw_hs ? 0 : (bus.awvalid ? aw_cnt + 1 : 0);
      w_cnt  <= w_hs  ? 0 : (bus.wvalid  ? w_cnt + 1  : 0);
      have_aw = aw_got || aw_hs;
      have_w  = w_got || w_hs;
      a = aw_hs ? bus.awaddr : aw_addr_l;
      d = w_hs ? bus.wdata : w_data_l;
      s = w_hs ? bus.wstrb : w_strb_l;
      if (bvalid_r && bus.bready) bvalid_r <= 1'b0;
      if (have_aw && have_w) begin
        bresp_r <= ((wr_addr_q.size() - wr_base) == b_err_at) ? 2'd2 : 2'd0;
        wr_addr_q.push_back(a);
        wr_data_q.push_back(d);
        wr_strb_q.push_back(s);
        bvalid_r <= 1'b1;
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end else begin
        aw_got <= have_aw; aw_addr_l <= a;
        w_got <= have_w; w_data_l <= d; w_strb_l <= s;
      end
      if (bus.arvalid && bus.arready) begin
        ri = rd_cyc_q.size() - rd_base;
        rdata_r <= (ri < 8) ? rd_vals[ri] : 32'h0;
        rd_cyc_q.push_back(cyc);
        rd_addr_q.push_back(bus.araddr);
        rvalid_r <= 1'b1;
      end else if (rvalid_r && bus.rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int slot, input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    cmd_waddr = IW'(slot);
    cmd_wdata = {op, addr, data};
    cmd_we = 1'b1;
    @(negedge ap_clk);
    cmd_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int k);
    k = 0;
    while (!(done || error) && k < budget) begin
      @(negedge ap_clk);
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] av_addr [5];
    logic [31:0] av_data [5];
    for (int i = 0; i < 8; i++) rd_vals[i] = 32'h0;
    av_addr[0] = 32'h10; av_addr[1] = 32'h1C; av_addr[2] = 32'h28; av_addr[3] = 32'h30; av_addr[4] = 32'h0;
    av_data[0] = 32'd0;  av_data[1] = 32'd120000; av_data[2] = 32'd5; av_data[3] = 32'd1; av_data[4] = 32'd129;

    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_idx", err_idx, 0);
    chk("rst_last_rdata", last_rdata, 0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);

    // Two measurer writes then END, zero-wait slave
    load(0, 2'd0, 32'h10010, 32'd13824);
    load(1, 2'd0, 32'h10000, 32'd129);
    load(2, 2'd3, 32'h0, 32'h0);
    wr_base = wr_addr_q.size();
    go();
    wait_end(40, k);
    chk("t1_within_12", (k <= 12), 1);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_nwr", wr_addr_q.size() - wr_base, 2);
    chk("t1_a0", wr_addr_q[wr_base], 32'h10010);
    chk("t1_d0", wr_data_q[wr_base], 32'h3600);
    chk("t1_s0", wr_strb_q[wr_base], 4'hF);
    chk("t1_a1", wr_addr_q[wr_base+1], 32'h10000);
    chk("t1_d1", wr_data_q[wr_base+1], 32'h81);
    chk("t1_s1", wr_strb_q[wr_base+1], 4'hF);

    // Averager sequence with awready delayed 3 cycles
    for (int i = 0; i < 5; i++) load(i, 2'd0, av_addr[i], av_data[i]);
    load(5, 2'd3, 32'h0, 32'h0);
    aw_dly = 3;
    wr_base = wr_addr_q.size();
    go();
    wait_end(200, k);
    chk("t2_done", done, 1);
    chk("t2_nwr", wr_addr_q.size() - wr_base, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_a%0d", i), wr_addr_q[wr_base+i], av_addr[i]);
      chk($sformatf("t2_d%0d", i), wr_data_q[wr_base+i], av_data[i]);
    end
    aw_dly = 0;

    // Poll for bit 1: 0, 0, 0, then 6
    rd_vals[3] = 32'h6;
    load(0, 2'd1, 32'h38, 32'h2);
    load(1, 2'd3, 32'h0, 32'h0);
    rd_base = rd_cyc_q.size();
    go();
    wait_end(400, k);
    chk("t3_done", done, 1);
    chk("t3_nrd", rd_cyc_q.size() - rd_base, 4);
    chk("t3_last_rdata", last_rdata, 32'h6);
    chk("t3_araddr", rd_addr_q[rd_base], 32'h38);
    for (int i = 1; i < 4; i++)
      chk($sformatf("t3_gap%0d", i), (rd_cyc_q[rd_base+i] - rd_cyc_q[rd_base+i-1]) >= POLL_GAP, 1);
    rd_vals[3] = 32'h0;

    // SLVERR on the second write
    load(0, 2'd0, 32'h100, 32'h1);
    load(1, 2'd0, 32'h104, 32'h2);
    load(2, 2'd0, 32'h108, 32'h3);
    load(3, 2'd3, 32'h0, 32'h0);
    wr_base = wr_addr_q.size();
    rd_base = rd_cyc_q.size();
    b_err_at = 1;
    go();
    wait_end(100, k);
    chk("t4_error", error, 1);
    chk("t4_err_idx", err_idx, 1);
    chk("t4_done", done, 0);
    repeat (20) @(negedge ap_clk);
    chk("t4_busy", busy, 0);
    chk("t4_nwr_quiet", wr_addr_q.size() - wr_base, 2);
    chk("t4_nrd_quiet", rd_cyc_q.size() - rd_base, 0);
    b_err_at = -1;
    wr_base = wr_addr_q.size();
    go();
    wait_end(100, k);
    chk("t4_rerun_error", error, 0);
    chk("t4_rerun_done", done, 1);
    chk("t4_rerun_nwr", wr_addr_q.size() - wr_base, 3);

    // WAIT of 100 between two writes: awvalid rises 104 cycles apart
    load(0, 2'd0, 32'h200, 32'hA);
    load(1, 2'd2, 32'h0, 32'd100);
    load(2, 2'd0, 32'h204, 32'hB);
    load(3, 2'd3, 32'h0, 32'h0);
    k = aw_rise_q.size();
    wr_base = wr_addr_q.size();
    go();
    wait_end(300, k);
    chk("t5_done", done, 1);
    chk("t5_nwr", wr_addr_q.size() - wr_base, 2);
    chk("t5_rise_gap", aw_rise_q[aw_rise_q.size()-1] - aw_rise_q[aw_rise_q.size()-2], 104);

    // Reset while in the WAIT
    go();
    repeat (20) @(negedge ap_clk);
    chk("t6_busy_pre", busy, 1);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_error", error, 0);
    chk("t6_err_idx", err_idx, 0);
    chk("t6_last_rdata", last_rdata, 0);
    chk("t6_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    wr_base = wr_addr_q.size();
    go();
    wait_end(300, k);
    chk("t6_table_kept_done", done, 1);
    chk("t6_table_kept_nwr", wr_addr_q.size() - wr_base, 2);

`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
    // Poll that never matches, POLL_MAX=4
    load(0, 2'd1, 32'h38, 32'h1);
    load(1, 2'd3, 32'h0, 32'h0);
    rd_base = rd_cyc_q.size();
    go();
    wait_end(400, k);
    chk("t7_error", error, 1);
    chk("t7_err_idx", err_idx, 0);
    repeat (40) @(negedge ap_clk);
    chk("t7_nrd", rd_cyc_q.size() - rd_base, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
